// File: rtl/fw_boot_loader.sv
// Firmware boot loader: streams an image into memory at LOAD_BASE, writes the
// 6502 reset vector, then releases the CPU reset after a hold period.
module fw_boot_loader #(
    parameter int unsigned            ADDR_WIDTH  = 16,
    parameter int unsigned            REG_WIDTH   = 8,
    parameter logic [ADDR_WIDTH-1:0]  LOAD_BASE   = 16'h8000,
    parameter int unsigned            MAX_FW_SIZE = 4096,
    parameter int unsigned            HOLD_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [REG_WIDTH-1:0]  in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [REG_WIDTH-1:0]  mem_din,
    output logic                  cpu_reset_n,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] byte_count
);

    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    // The image plus the vector slots must fit below 0xFFFC without wrapping.
    if (32'(LOAD_BASE) + 32'(MAX_FW_SIZE) > 32'hFFFC) begin : g_bad_size
        $error("fw_boot_loader: LOAD_BASE + MAX_FW_SIZE exceeds 0xFFFC");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("fw_boot_loader: HOLD_CYCLES must be >= 1");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        VEC_LO = 3'd2,
        VEC_HI = 3'd3,
        HOLD   = 3'd4,
        RUN    = 3'd5,
        ERR    = 3'd6
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   byte_count_q, byte_count_d;
    logic [HOLD_W-1:0]       hold_cnt_q, hold_cnt_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [REG_WIDTH-1:0]    mem_din_q, mem_din_d;
    logic                    cpu_reset_n_q, cpu_reset_n_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic                    accept;

    assign in_ready = (state_q == LOAD);
    assign accept   = in_valid && in_ready;

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            byte_count_q  <= '0;
            hold_cnt_q    <= '0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_din_q     <= '0;
            cpu_reset_n_q <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_count_q  <= byte_count_d;
            hold_cnt_q    <= hold_cnt_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_din_q     <= mem_din_d;
            cpu_reset_n_q <= cpu_reset_n_d;
            done_q        <= done_d;
            error_q       <= error_d;
        end
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d       = state_q;
        byte_count_d  = byte_count_q;
        hold_cnt_d    = hold_cnt_q;
        mem_we_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_din_d     = mem_din_q;
        cpu_reset_n_d = 1'b0;
        done_d        = done_q;
        error_d       = error_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = LOAD;
                    byte_count_d = '0;
                end
            end
            LOAD: begin
                if (accept) begin
                    mem_we_d     = 1'b1;
                    mem_addr_d   = LOAD_BASE + byte_count_q;
                    mem_din_d    = in_data;
                    byte_count_d = byte_count_q + ADDR_WIDTH'(1);
                    if (in_last) begin
                        state_d = VEC_LO;
                    end else if (byte_count_q == ADDR_WIDTH'(MAX_FW_SIZE - 1)) begin
                        state_d = ERR;
                        error_d = 1'b1;
                    end
                end
            end
            VEC_LO: begin
                mem_we_d   = 1'b1;
                mem_addr_d = ADDR_WIDTH'(16'hFFFC);
                mem_din_d  = REG_WIDTH'(LOAD_BASE);
                state_d    = VEC_HI;
            end
            VEC_HI: begin
                mem_we_d   = 1'b1;
                mem_addr_d = ADDR_WIDTH'(16'hFFFD);
                mem_din_d  = REG_WIDTH'(LOAD_BASE >> 8);
                state_d    = HOLD;
                hold_cnt_d = '0;
            end
            HOLD: begin
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                    state_d       = RUN;
                    cpu_reset_n_d = 1'b1;
                    done_d        = 1'b1;
                end
            end
            RUN: begin
                cpu_reset_n_d = 1'b1;
                done_d        = 1'b1;
            end
            ERR: begin
                error_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_din     = mem_din_q;
    assign cpu_reset_n = cpu_reset_n_q;
    assign done        = done_q;
    assign error       = error_q;
    assign byte_count  = byte_count_q;

endmodule

// File: doc/fw_boot_loader.md
Name: fw_boot_loader

Overview:
- Sequential boot loader upstream of cpu_top and mem.
- Accepts a firmware byte stream on a valid/ready handshake and writes it into mem starting at LOAD_BASE.
- Writes the 6502 reset vector (0xFFFC/0xFFFD) to point at LOAD_BASE, then releases the CPU reset after a hold period.
- Replaces bench-side memory override as the synthesizable path for loading programs.

Parameters:
- ADDR_WIDTH, 16, address bus width.
- REG_WIDTH, 8, data width.
- LOAD_BASE, 16'h8000, first address written. Constraint: LOAD_BASE + MAX_FW_SIZE <= 16'hFFFC (elaboration-time check).
- MAX_FW_SIZE, 4096, maximum image length in bytes.
- HOLD_CYCLES, 8, cycles cpu_reset_n is held low after the vector write; must be >= 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins a load; honoured only in IDLE.
- in_valid  in  1  stream byte valid.
- in_data  in  REG_WIDTH  stream byte.
- in_last  in  1  marks the final byte of the image; qualified by in_valid.
- in_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  memory write enable (registered).
- mem_addr  out  ADDR_WIDTH  memory write address (registered).
- mem_din  out  REG_WIDTH  memory write data (registered).
- cpu_reset_n  out  1  reset to cpu_top, active low (registered).
- done  out  1  load complete and CPU released; sticky.
- error  out  1  image overflow; sticky.
- byte_count  out  ADDR_WIDTH  number of image bytes accepted.

Behaviour:
- Asynchronous reset (reset_n=0), effective immediately:
  - state=IDLE.
  - mem_we=0, mem_addr=0, mem_din=0.
  - cpu_reset_n=0, done=0, error=0, byte_count=0.
  - in_ready=0.
  - A reset mid-load abandons the load; bytes already written stay in mem.
- States: IDLE, LOAD, VEC_LO, VEC_HI, HOLD, RUN, ERR.
- in_ready = (state==LOAD), decoded combinationally from the state register. A beat is accepted when in_valid && in_ready.
- IDLE: on start -> LOAD, byte_count=0. Otherwise stay. mem_we=0.
- LOAD, on each accepted beat:
  - Next cycle drive mem_we=1, mem_addr=LOAD_BASE+byte_count (pre-increment value), mem_din=in_data.
  - byte_count increments.
  - Latency from accept to write is exactly 1 cycle.
  - A cycle with no accepted beat drives mem_we=0 on the next cycle.
- LOAD transitions:
  - Accepted beat with in_last=1 -> VEC_LO.
  - Accepted beat with in_last=0 and byte_count==MAX_FW_SIZE-1 before increment -> ERR. That byte is still written.
  - in_last=1 on the MAX_FW_SIZE-th byte is legal -> VEC_LO.
- VEC_LO (1 cycle): next cycle mem_we=1, mem_addr=16'hFFFC, mem_din=LOAD_BASE[7:0]. -> VEC_HI.
- VEC_HI (1 cycle): next cycle mem_we=1, mem_addr=16'hFFFD, mem_din=LOAD_BASE[15:8]. -> HOLD, hold counter=0.
- HOLD:
  - mem_we=0, cpu_reset_n=0.
  - Counter increments each cycle.
  - When counter==HOLD_CYCLES-1 -> RUN.
- RUN: cpu_reset_n=1 and done=1 from the first RUN cycle. Stays until reset_n; start is ignored.
- ERR: error=1, cpu_reset_n=0, in_ready=0, mem_we=0 after the final byte write. Sticky until reset_n; start is ignored.
- start outside IDLE is ignored in every state.
- in_valid in non-LOAD states: no effect, no write, byte_count unchanged.
- in_last without in_valid: ignored.
- mem_addr/mem_din hold their last values when mem_we=0.
- byte_count saturates at MAX_FW_SIZE, which the ERR transition guarantees. Address arithmetic never wraps because of the parameter constraint.

Test Plan:
- Nominal load:
  - Stimulus: reset; start; stream 3 bytes A9,05,EA with in_last on EA, in_valid held high.
  - Required: writes 8000=A9, 8001=05, 8002=EA on consecutive cycles, each 1 cycle after accept; then FFFC=00, FFFD=80.
  - Then cpu_reset_n low for 8 cycles, then cpu_reset_n=1, done=1, byte_count=3.
- Backpressure/gaps:
  - Stimulus: in_valid toggling 1,0,0,1,1 with 3 bytes.
  - Required: exactly 3 writes at 8000..8002, no write on gap cycles, data in order.
- Overflow:
  - Stimulus: MAX_FW_SIZE=4; stream 5 bytes with no in_last.
  - Required: writes 8000..8003, then error=1, in_ready=0, 5th byte not accepted, cpu_reset_n stays 0, done=0.
- Exact fit:
  - Stimulus: MAX_FW_SIZE=4; 4 bytes, in_last on the 4th.
  - Required: error=0, vector written, done=1.
- Reset mid-load:
  - Stimulus: reset_n=0 asynchronously after 2 bytes.
  - Required: all outputs return to reset values immediately. A new start plus 1-byte image (EA, last) completes with byte_count=1 and FFFC/FFFD=00/80.
- Ignored inputs:
  - Stimulus: start pulses during LOAD and RUN; in_valid=1 in IDLE with no start.
  - Required: no state change, no mem_we, byte_count unchanged.
